sat_ramp_counter: RTL

SAT_RAMP_COUNTER -- requirements
Module: sat_ramp_counter

---
 rtl/sat_ramp_pkg.sv | 15 +
 rtl/sat_ramp_next.sv | 62 ++++++
 rtl/sat_ramp_counter.sv | 110 +++++++++++
 3 files changed

// File: rtl/sat_ramp_pkg.sv
// ----------------------------------------------------------------------------
// sat_ramp_pkg
// Shared constants for the saturating/wrapping ramp counter.
//   MODE_SAT / MODE_WRAP : encoding of the wrap_mode input
//   DIR_UP   / DIR_DOWN  : encoding of the dir_down input
// ----------------------------------------------------------------------------
package sat_ramp_pkg;

    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/sat_ramp_next.sv
// ----------------------------------------------------------------------------
// sat_ramp_next
// Combinational next-count for one enabled step of the ramp counter.
// Ports:
//   count      in  WIDTH  current registered count
//   dir        in  1      DIR_UP / DIR_DOWN
//   mode       in  1      MODE_SAT / MODE_WRAP
//   next_count out WIDTH  count after one step of STEP
//   wrap_flag  out 1      this step crossed a bound in wrap mode
// ----------------------------------------------------------------------------
module sat_ramp_next
    import sat_ramp_pkg::*;
#(
    parameter int unsigned      WIDTH   = 2,
    parameter logic [WIDTH:0]   MAX_VAL = {1'b0, {WIDTH{1'b1}}},
    parameter logic [WIDTH:0]   STEP    = (WIDTH + 1)'(1)
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_flag
);

    // One extra bit keeps count+STEP and count+MAX_VAL+1 from overflowing.
    logic [WIDTH:0] w_cnt_ext;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_range;

    assign w_cnt_ext = {1'b0, count};
    assign w_sum     = w_cnt_ext + STEP;
    assign w_range   = MAX_VAL + (WIDTH + 1)'(1);

    always_comb begin
        next_count = count;
        wrap_flag  = 1'b0;
        if (dir == DIR_UP) begin
            if (w_sum > MAX_VAL) begin
                if (mode == MODE_WRAP) begin
                    next_count = WIDTH'(w_sum - w_range);
                    wrap_flag  = 1'b1;
                end else begin
                    next_count = MAX_VAL[WIDTH-1:0];
                end
            end else begin
                next_count = WIDTH'(w_sum);
            end
        end else begin
            if (w_cnt_ext < STEP) begin
                if (mode == MODE_WRAP) begin
                    next_count = WIDTH'(w_cnt_ext + w_range - STEP);
                    wrap_flag  = 1'b1;
                end else begin
                    next_count = '0;
                end
            end else begin
                next_count = WIDTH'(w_cnt_ext - STEP);
            end
        end
    end

endmodule

// File: rtl/sat_ramp_counter.sv
// ----------------------------------------------------------------------------
// sat_ramp_counter
// Up/down counter over 0..MAX_VAL stepping by STEP, saturating or wrapping,
// with synchronous load and registered status pulses.
// Ports:
//   clk         in  1      rising-edge clock
//   reset       in  1      asynchronous active-low reset
//   en          in  1      take one step this cycle
//   dir_down    in  1      0 = up, 1 = down
//   wrap_mode   in  1      0 = saturate, 1 = wrap
//   load        in  1      load min(load_val, MAX_VAL); beats en
//   load_val    in  WIDTH  value to load
//   clr_sticky  in  1      clear sticky_max
//   count       out WIDTH  registered count
//   at_max      out 1      count == MAX_VAL
//   at_min      out 1      count == 0
//   max_pulse   out 1      first cycle count equals MAX_VAL
//   wrap_pulse  out 1      cycle after a wrapping step
//   sticky_max  out 1      set while at_max, held until clr_sticky
// ----------------------------------------------------------------------------
module sat_ramp_counter
    import sat_ramp_pkg::*;
#(
    parameter int unsigned      WIDTH   = 2,
    parameter logic [WIDTH:0]   MAX_VAL = {1'b0, {WIDTH{1'b1}}},
    parameter logic [WIDTH:0]   STEP    = (WIDTH + 1)'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir_down,
    input  logic             wrap_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             max_pulse,
    output logic             wrap_pulse,
    output logic             sticky_max
);

    logic [WIDTH-1:0] r_count;
    logic             r_max_pulse;
    logic             r_wrap_pulse;
    logic             r_sticky;

    logic [WIDTH-1:0] w_step_next;
    logic             w_step_wrap;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_count_d;
    logic             w_wrap_d;
    logic             w_at_max;
    logic             w_max_pulse_d;
    logic             w_sticky_d;

    sat_ramp_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP    (STEP)
    ) u_next (
        .count      (r_count),
        .dir        (dir_down),
        .mode       (wrap_mode),
        .next_count (w_step_next),
        .wrap_flag  (w_step_wrap)
    );

    assign w_load_clamped = ({1'b0, load_val} > MAX_VAL) ? MAX_VAL[WIDTH-1:0] : load_val;

    always_comb begin
        w_count_d = r_count;
        w_wrap_d  = 1'b0;
        if (load) begin
            w_count_d = w_load_clamped;
        end else if (en) begin
            w_count_d = w_step_next;
            w_wrap_d  = w_step_wrap;
        end
    end

    assign w_at_max      = ({1'b0, r_count} == MAX_VAL);
    // Pulse only on entry into MAX_VAL, never while holding there.
    assign w_max_pulse_d = ({1'b0, w_count_d} == MAX_VAL) && !w_at_max;
    // Set has priority over clear.
    assign w_sticky_d    = w_at_max | (r_sticky & ~clr_sticky);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_max_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_sticky     <= 1'b0;
        end else begin
            r_count      <= w_count_d;
            r_max_pulse  <= w_max_pulse_d;
            r_wrap_pulse <= w_wrap_d;
            r_sticky     <= w_sticky_d;
        end
    end

    assign count      = r_count;
    assign at_max     = w_at_max;
    assign at_min     = (r_count == '0);
    assign max_pulse  = r_max_pulse;
    assign wrap_pulse = r_wrap_pulse;
    assign sticky_max = r_sticky;

endmodule
